// File: rtl/aircon_display.sv
// Aircon front-panel display driver: one-hot thermostat mode + turbo -> registered bar graph and error flag.
// Optional error blink pattern enabled by defining AIRCON_ERR_BLINK_EN.
module aircon_display #(
    parameter int BLINK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Thermo_In,
    input  logic       Turbo_In,
    output logic [7:0] BGraph_Out,
    output logic       Err_Out
);

    if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_blink_div
        $error("aircon_display: BLINK_DIV must be in 1..255");
    end

    logic [7:0] level;
    logic       legal;
    logic [7:0] err_bg;

    // Turbo adds exactly one bar on top of each mode's base level; OFF stays dark.
    always_comb begin
        level = 8'h00;
        legal = 1'b1;
        case (Thermo_In)
            4'b0000: level = 8'h00;
            4'b0001: level = Turbo_In ? 8'h03 : 8'h01;
            4'b0010: level = Turbo_In ? 8'h0F : 8'h07;
            4'b0100: level = Turbo_In ? 8'h3F : 8'h1F;
            4'b1000: level = Turbo_In ? 8'hFF : 8'h7F;
            default: legal = 1'b0;
        endcase
    end

`ifdef AIRCON_ERR_BLINK_EN
    localparam logic [7:0] BLINK_RELOAD = 8'(BLINK_DIV - 1);

    logic [7:0] blink_cnt_q;
    logic [7:0] blink_cnt_d;
    logic       phase_q;
    logic       phase_d;

    // Err_Out doubles as "previous cycle was an error", so phase restarts at 1 on entry.
    always_comb begin
        blink_cnt_d = 8'h00;
        phase_d     = 1'b0;
        if (!legal) begin
            if (!Err_Out) begin
                phase_d     = 1'b1;
                blink_cnt_d = BLINK_RELOAD;
            end else if (blink_cnt_q == 8'h00) begin
                phase_d     = ~phase_q;
                blink_cnt_d = BLINK_RELOAD;
            end else begin
                phase_d     = phase_q;
                blink_cnt_d = blink_cnt_q - 8'h01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= 8'h00;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign err_bg = phase_d ? 8'hFF : 8'h00;
`else
    assign err_bg = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BGraph_Out <= 8'h00;
            Err_Out    <= 1'b0;
        end else begin
            BGraph_Out <= legal ? level : err_bg;
            Err_Out    <= ~legal;
        end
    end

endmodule

// File: tb/tb_aircon_display.sv
// Scoreboard bench for aircon_display: driver queues expected outputs, monitor checks one cycle after each sample.
module tb_aircon_display;

    typedef struct {
        logic [7:0] bg;
        logic       err;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] Thermo_In;
    logic       Turbo_In;
    logic [7:0] BGraph_Out;
    logic       Err_Out;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    aircon_display #(.BLINK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Thermo_In  (Thermo_In),
        .Turbo_In   (Turbo_In),
        .BGraph_Out (BGraph_Out),
        .Err_Out    (Err_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] bg, input logic err);
        checks++;
        if (BGraph_Out !== bg || Err_Out !== err) begin
            errors++;
            $display("FAIL %s: got bg=%02h err=%b, expected bg=%02h err=%b",
                     name, BGraph_Out, Err_Out, bg, err);
        end
    endtask

    // Monitor: every sample edge presents an output; pop and compare if one is expected.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0 && !rst) begin
                e = exp_q.pop_front();
                check(e.name, e.bg, e.err);
            end
        end
    end

    task automatic apply(input logic [3:0] th, input logic tb, input logic [7:0] bg,
                         input logic err, input string name);
        exp_t e;
        @(negedge clk);
        Thermo_In = th;
        Turbo_In  = tb;
        e.bg   = bg;
        e.err  = err;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [3:0] codes[5]   = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] lv_plain[5] = '{8'h00, 8'h01, 8'h07, 8'h1F, 8'h7F};
    logic [7:0] lv_turbo[5] = '{8'h00, 8'h03, 8'h0F, 8'h3F, 8'hFF};

    initial begin
        logic [7:0] blink_bg;
        rst       = 1'b0;
        Thermo_In = 4'b1000;
        Turbo_In  = 1'b1;
        #1 rst = 1'b1;
        #1 check("reset_async", 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("reset_held", 8'h00, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        apply(4'b1000, 1'b1, 8'hFF, 1'b0, "first_after_reset");

        for (int i = 0; i < 5; i++)
            apply(codes[i], 1'b0, lv_plain[i], 1'b0, $sformatf("sweep_plain_%0d", i));
        for (int i = 0; i < 5; i++)
            apply(codes[i], 1'b1, lv_turbo[i], 1'b0, $sformatf("sweep_turbo_%0d", i));

`ifdef AIRCON_ERR_BLINK_EN
        apply(4'b1111, 1'b0, 8'hFF, 1'b1, "err_1111");
        apply(4'b0111, 1'b1, 8'hFF, 1'b1, "err_0111_turbo");
`else
        apply(4'b1111, 1'b0, 8'h00, 1'b1, "err_1111");
        apply(4'b0111, 1'b1, 8'h00, 1'b1, "err_0111_turbo");
`endif
        apply(4'b0100, 1'b0, 8'h1F, 1'b0, "recover_0100");

        for (int i = 0; i < 16; i++) begin
`ifdef AIRCON_ERR_BLINK_EN
            blink_bg = ((i / 4) % 2 == 0) ? 8'hFF : 8'h00;
`else
            blink_bg = 8'h00;
`endif
            apply(4'b0011, i[0], blink_bg, 1'b1, $sformatf("blink_%0d", i));
        end
        apply(4'b0001, 1'b0, 8'h01, 1'b0, "recover_0001");
`ifdef AIRCON_ERR_BLINK_EN
        apply(4'b1100, 1'b0, 8'hFF, 1'b1, "blink_restart");
`else
        apply(4'b1100, 1'b0, 8'h00, 1'b1, "err_restart");
`endif
        apply(4'b0010, 1'b1, 8'h0F, 1'b0, "mode_and_turbo_same_edge");
        apply(4'b1000, 1'b1, 8'hFF, 1'b0, "high_cool_turbo");
        drain();

        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("reset_mid_cycle", 8'h00, 1'b0);
        @(posedge clk);
        #1 check("reset_mid_held", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0100, 1'b1, 8'h3F, 1'b0, "after_mid_reset");
        apply(4'b0000, 1'b1, 8'h00, 1'b0, "off_turbo_ignored");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
